// File: rtl/npu_pkg.sv
// Shared NPU constants: result width, destination encoding and the tag type
// carried alongside each sigmoid evaluation.
package npu_pkg;

    localparam int unsigned NPU_DATA_W = 16;

    // Destination encoding sampled with the sigmoid input strobe.
    localparam logic NPU_DEST_SFIFO = 1'b0;
    localparam logic NPU_DEST_OFIFO = 1'b1;

    // One stage of the latency-matching tag pipeline.
    typedef struct packed {
        logic valid;
        logic dest;
    } npu_tag_t;

endpackage

// File: rtl/npu_sigmoid_out_buffer_if.sv
// Bundle of scheduler, sigmoid-unit, PE and host signals around the sigmoid
// output buffer. The slave modport is the buffer's view.
interface npu_sigmoid_out_buffer_if #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SFIFO_DEPTH = 16
);

    logic                           npu_sched_sigmoid_input_en;
    logic                           npu_sched_sigmoid_dest_sel;
    logic [DATA_W-1:0]              npu_sigmoid_dout;
    logic                           npu_sfifo_rd_en;
    logic [DATA_W-1:0]              npu_sfifo_dout;
    logic                           npu_sfifo_empty;
    logic [$clog2(SFIFO_DEPTH):0]   npu_sfifo_count;
    logic                           npu_sfifo_credit;
    logic                           npu_ofifo_rd_en;
    logic [DATA_W-1:0]              npu_ofifo_dout;
    logic                           npu_ofifo_empty;
    logic                           npu_ofifo_credit;
    logic                           npu_overflow_err;

    modport slave (
        input  npu_sched_sigmoid_input_en,
        input  npu_sched_sigmoid_dest_sel,
        input  npu_sigmoid_dout,
        input  npu_sfifo_rd_en,
        input  npu_ofifo_rd_en,
        output npu_sfifo_dout,
        output npu_sfifo_empty,
        output npu_sfifo_count,
        output npu_sfifo_credit,
        output npu_ofifo_dout,
        output npu_ofifo_empty,
        output npu_ofifo_credit,
        output npu_overflow_err
    );

    modport master (
        output npu_sched_sigmoid_input_en,
        output npu_sched_sigmoid_dest_sel,
        output npu_sigmoid_dout,
        output npu_sfifo_rd_en,
        output npu_ofifo_rd_en,
        input  npu_sfifo_dout,
        input  npu_sfifo_empty,
        input  npu_sfifo_count,
        input  npu_sfifo_credit,
        input  npu_ofifo_dout,
        input  npu_ofifo_empty,
        input  npu_ofifo_credit,
        input  npu_overflow_err
    );

endinterface

// File: rtl/npu_fifo.sv
// Count-based first-word-fall-through FIFO. Output reads zero when empty;
// a write into a full FIFO without a same-cycle pop is dropped and flagged.
module npu_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, empty, do_wr, do_rd;

    // Accept/drop decisions and next pointer/count state.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        do_rd      = rd_en_i && !empty;
        // A pop frees the slot in the same cycle, so a full FIFO still takes the write.
        do_wr      = wr_en_i && (!full || do_rd);
        overflow_o = wr_en_i && full && !do_rd;

        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // FWFT head with zero-when-empty output.
    always_comb begin
        rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
        empty_o   = empty;
        count_o   = count_q;
    end

endmodule

// File: rtl/npu_sigmoid_out_buffer.sv
// Sigmoid result capture: a tag pipeline matching the sigmoid unit latency
// steers each result into the PE-feedback FIFO or the host output FIFO, and
// per-destination credits keep the scheduler from overcommitting either FIFO.
module npu_sigmoid_out_buffer
    import npu_pkg::*;
#(
    parameter int unsigned DATA_W      = NPU_DATA_W,
    parameter int unsigned SIG_LAT     = 2,
    parameter int unsigned SFIFO_DEPTH = 16,
    parameter int unsigned OFIFO_DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       npu_rst_n,
    npu_sigmoid_out_buffer_if.slave    bus
);

    localparam int unsigned IFW = $clog2(SIG_LAT + 1);

    npu_tag_t                     tag_q [SIG_LAT];
    npu_tag_t                     tag_d [SIG_LAT];
    logic                         err_q, err_d;
    logic                         sfifo_wr, ofifo_wr;
    logic                         sfifo_ovf, ofifo_ovf;
    logic [$clog2(OFIFO_DEPTH):0] ofifo_count;
    logic [IFW-1:0]               s_inflight, o_inflight;

    // Tag pipeline shift: stage 0 samples the strobe every cycle.
    always_comb begin
        tag_d[0].valid = bus.npu_sched_sigmoid_input_en;
        tag_d[0].dest  = bus.npu_sched_sigmoid_dest_sel;
        for (int i = 1; i < int'(SIG_LAT); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag registers; reset discards every in-flight result.
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            for (int i = 0; i < int'(SIG_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(SIG_LAT); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Last stage lines up with valid sigmoid output; route by its dest.
    always_comb begin
        sfifo_wr = tag_q[SIG_LAT-1].valid && (tag_q[SIG_LAT-1].dest == NPU_DEST_SFIFO);
        ofifo_wr = tag_q[SIG_LAT-1].valid && (tag_q[SIG_LAT-1].dest == NPU_DEST_OFIFO);
    end

    // In-flight counts and credits from registered state only; pops are not
    // credited until they land in the count, which keeps credit conservative.
    always_comb begin
        s_inflight = '0;
        o_inflight = '0;
        for (int i = 0; i < int'(SIG_LAT); i++) begin
            if (tag_q[i].valid && tag_q[i].dest == NPU_DEST_SFIFO) begin
                s_inflight = s_inflight + IFW'(1);
            end
            if (tag_q[i].valid && tag_q[i].dest == NPU_DEST_OFIFO) begin
                o_inflight = o_inflight + IFW'(1);
            end
        end
        bus.npu_sfifo_credit = (32'(bus.npu_sfifo_count) + 32'(s_inflight)) < SFIFO_DEPTH;
        bus.npu_ofifo_credit = (32'(ofifo_count) + 32'(o_inflight)) < OFIFO_DEPTH;
    end

    // Sticky overflow: set by any dropped write, cleared only by reset.
    always_comb begin
        err_d                = err_q | sfifo_ovf | ofifo_ovf;
        bus.npu_overflow_err = err_q;
    end

    // Overflow flag register.
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    npu_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SFIFO_DEPTH)
    ) u_sfifo (
        .clk_i      (CLK),
        .rst_ni     (npu_rst_n),
        .wr_en_i    (sfifo_wr),
        .wr_data_i  (bus.npu_sigmoid_dout),
        .rd_en_i    (bus.npu_sfifo_rd_en),
        .rd_data_o  (bus.npu_sfifo_dout),
        .empty_o    (bus.npu_sfifo_empty),
        .count_o    (bus.npu_sfifo_count),
        .overflow_o (sfifo_ovf)
    );

    npu_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OFIFO_DEPTH)
    ) u_ofifo (
        .clk_i      (CLK),
        .rst_ni     (npu_rst_n),
        .wr_en_i    (ofifo_wr),
        .wr_data_i  (bus.npu_sigmoid_dout),
        .rd_en_i    (bus.npu_ofifo_rd_en),
        .rd_data_o  (bus.npu_ofifo_dout),
        .empty_o    (bus.npu_ofifo_empty),
        .count_o    (ofifo_count),
        .overflow_o (ofifo_ovf)
    );

endmodule

// File: tb/tb_npu_sigmoid_out_buffer.sv
// Directed bench for the sigmoid output buffer. Inputs change #1 after each
// rising edge; outputs are sampled at that same point, before new drives.
module tb_npu_sigmoid_out_buffer;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    npu_sigmoid_out_buffer_if #(.DATA_W(16), .SFIFO_DEPTH(DEPTH)) bus ();

    npu_sigmoid_out_buffer #(
        .DATA_W      (16),
        .SIG_LAT     (LAT),
        .SFIFO_DEPTH (DEPTH),
        .OFIFO_DEPTH (DEPTH)
    ) dut (
        .CLK       (clk),
        .npu_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.npu_sched_sigmoid_input_en = 1'b0;
        bus.npu_sched_sigmoid_dest_sel = 1'b0;
        bus.npu_sigmoid_dout           = 16'h0;
        bus.npu_sfifo_rd_en            = 1'b0;
        bus.npu_ofifo_rd_en            = 1'b0;
    endtask

    // n consecutive strobes; strobe k goes to dests[k] and its result is base+k.
    task automatic issue(input int n, input logic [31:0] dests, input logic [15:0] base);
        for (int c = 0; c < n + int'(LAT); c++) begin
            bus.npu_sched_sigmoid_input_en = (c < n);
            bus.npu_sched_sigmoid_dest_sel = (c < n) ? dests[c] : 1'b0;
            bus.npu_sigmoid_dout = (c >= int'(LAT)) ? base + 16'(c - int'(LAT)) : 16'h0;
            step();
        end
        idle_inputs();
    endtask

    task automatic pop_s(input logic [15:0] exp);
        checks++;
        if (bus.npu_sfifo_dout !== exp || bus.npu_sfifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL sfifo_pop: dout=%h empty=%b, expected dout=%h empty=0",
                     bus.npu_sfifo_dout, bus.npu_sfifo_empty, exp);
        end
        bus.npu_sfifo_rd_en = 1'b1;
        step();
        bus.npu_sfifo_rd_en = 1'b0;
    endtask

    task automatic pop_o(input logic [15:0] exp);
        checks++;
        if (bus.npu_ofifo_dout !== exp || bus.npu_ofifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL ofifo_pop: dout=%h empty=%b, expected dout=%h empty=0",
                     bus.npu_ofifo_dout, bus.npu_ofifo_empty, exp);
        end
        bus.npu_ofifo_rd_en = 1'b1;
        step();
        bus.npu_ofifo_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.npu_sfifo_empty, bus.npu_ofifo_empty} !== 2'b11) begin
            errors++;
            $display("FAIL reset_empty: got %b%b, expected 11",
                     bus.npu_sfifo_empty, bus.npu_ofifo_empty);
        end
        checks++;
        if (bus.npu_sfifo_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, expected 0", bus.npu_sfifo_count);
        end
        checks++;
        if ({bus.npu_sfifo_credit, bus.npu_ofifo_credit} !== 2'b11) begin
            errors++;
            $display("FAIL reset_credit: got %b%b, expected 11",
                     bus.npu_sfifo_credit, bus.npu_ofifo_credit);
        end
        checks++;
        if (bus.npu_sfifo_dout !== 16'h0 || bus.npu_ofifo_dout !== 16'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h/%h, expected 0000/0000",
                     bus.npu_sfifo_dout, bus.npu_ofifo_dout);
        end
        checks++;
        if (bus.npu_overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b, expected 0", bus.npu_overflow_err);
        end
    endtask

    task automatic test_single();
        bus.npu_sched_sigmoid_input_en = 1'b1;
        bus.npu_sched_sigmoid_dest_sel = 1'b0;
        step();
        bus.npu_sched_sigmoid_input_en = 1'b0;
        step();
        bus.npu_sigmoid_dout = 16'h1234;
        // Write lands at the end of this cycle, so the FIFO is still empty here.
        checks++;
        if (bus.npu_sfifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_early: empty=%b, expected 1", bus.npu_sfifo_empty);
        end
        step();
        bus.npu_sigmoid_dout = 16'h0;
        checks++;
        if (bus.npu_sfifo_dout !== 16'h1234 || bus.npu_sfifo_empty !== 1'b0 ||
            bus.npu_sfifo_count !== 5'd1) begin
            errors++;
            $display("FAIL single_visible: dout=%h empty=%b count=%0d, expected 1234 0 1",
                     bus.npu_sfifo_dout, bus.npu_sfifo_empty, bus.npu_sfifo_count);
        end
        checks++;
        if (bus.npu_ofifo_empty !== 1'b1 || bus.npu_ofifo_dout !== 16'h0) begin
            errors++;
            $display("FAIL single_ofifo: empty=%b dout=%h, expected 1 0000",
                     bus.npu_ofifo_empty, bus.npu_ofifo_dout);
        end
        pop_s(16'h1234);
        checks++;
        if (bus.npu_sfifo_empty !== 1'b1 || bus.npu_sfifo_dout !== 16'h0 ||
            bus.npu_sfifo_count !== 5'd0) begin
            errors++;
            $display("FAIL single_drain: empty=%b dout=%h count=%0d, expected 1 0000 0",
                     bus.npu_sfifo_empty, bus.npu_sfifo_dout, bus.npu_sfifo_count);
        end
        // Pop on empty must be ignored.
        bus.npu_sfifo_rd_en = 1'b1;
        step();
        bus.npu_sfifo_rd_en = 1'b0;
        checks++;
        if (bus.npu_sfifo_count !== 5'd0 || bus.npu_sfifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_pop: count=%0d empty=%b, expected 0 1",
                     bus.npu_sfifo_count, bus.npu_sfifo_empty);
        end
    endtask

    task automatic test_back_to_back();
        issue(8, 32'hAA, 16'h0001);
        checks++;
        if (bus.npu_sfifo_count !== 5'd4) begin
            errors++;
            $display("FAIL burst_count: got %0d, expected 4", bus.npu_sfifo_count);
        end
        for (int k = 0; k < 4; k++) pop_s(16'(2 * k + 1));
        for (int k = 0; k < 4; k++) pop_o(16'(2 * k + 2));
        checks++;
        if (bus.npu_sfifo_empty !== 1'b1 || bus.npu_ofifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL burst_drain: empty=%b%b, expected 11",
                     bus.npu_sfifo_empty, bus.npu_ofifo_empty);
        end
    endtask

    task automatic test_credit();
        for (int c = 0; c < 18; c++) begin
            checks++;
            if (bus.npu_sfifo_credit !== (c < 16)) begin
                errors++;
                $display("FAIL credit_cycle%0d: got %b, expected %b",
                         c, bus.npu_sfifo_credit, (c < 16));
            end
            bus.npu_sched_sigmoid_input_en = (c < 16);
            bus.npu_sched_sigmoid_dest_sel = 1'b0;
            bus.npu_sigmoid_dout = (c >= 2) ? 16'(16'h100 + c - 2) : 16'h0;
            step();
        end
        idle_inputs();
        checks++;
        if (bus.npu_sfifo_count !== 5'd16 || bus.npu_sfifo_credit !== 1'b0 ||
            bus.npu_ofifo_credit !== 1'b1) begin
            errors++;
            $display("FAIL credit_full: count=%0d scred=%b ocred=%b, expected 16 0 1",
                     bus.npu_sfifo_count, bus.npu_sfifo_credit, bus.npu_ofifo_credit);
        end
        pop_s(16'h100);
        checks++;
        if (bus.npu_sfifo_count !== 5'd15 || bus.npu_sfifo_credit !== 1'b1) begin
            errors++;
            $display("FAIL credit_return: count=%0d credit=%b, expected 15 1",
                     bus.npu_sfifo_count, bus.npu_sfifo_credit);
        end
        issue(1, 32'h0, 16'h110);
        checks++;
        if (bus.npu_sfifo_count !== 5'd16 || bus.npu_sfifo_dout !== 16'h101) begin
            errors++;
            $display("FAIL credit_refill: count=%0d head=%h, expected 16 0101",
                     bus.npu_sfifo_count, bus.npu_sfifo_dout);
        end
    endtask

    task automatic test_full_pop_write();
        bus.npu_sched_sigmoid_input_en = 1'b1;
        step();
        bus.npu_sched_sigmoid_input_en = 1'b0;
        step();
        bus.npu_sigmoid_dout = 16'h111;
        bus.npu_sfifo_rd_en  = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (bus.npu_sfifo_count !== 5'd16 || bus.npu_sfifo_dout !== 16'h102 ||
            bus.npu_overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL full_popwrite: count=%0d head=%h err=%b, expected 16 0102 0",
                     bus.npu_sfifo_count, bus.npu_sfifo_dout, bus.npu_overflow_err);
        end
    endtask

    task automatic test_overflow();
        issue(1, 32'h0, 16'h0BAD);
        checks++;
        if (bus.npu_sfifo_count !== 5'd16 || bus.npu_overflow_err !== 1'b1 ||
            bus.npu_sfifo_dout !== 16'h102) begin
            errors++;
            $display("FAIL overflow: count=%0d err=%b head=%h, expected 16 1 0102",
                     bus.npu_sfifo_count, bus.npu_overflow_err, bus.npu_sfifo_dout);
        end
        // Dropped word must not appear anywhere in the drained sequence.
        for (int k = 0; k < 14; k++) pop_s(16'(16'h102 + k));
        pop_s(16'h110);
        pop_s(16'h111);
        checks++;
        if (bus.npu_sfifo_empty !== 1'b1 || bus.npu_overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: empty=%b err=%b, expected 1 1",
                     bus.npu_sfifo_empty, bus.npu_overflow_err);
        end
    endtask

    task automatic test_reset_inflight();
        issue(5, 32'h0, 16'h200);
        bus.npu_sched_sigmoid_input_en = 1'b1;
        bus.npu_sched_sigmoid_dest_sel = 1'b0;
        step();
        bus.npu_sched_sigmoid_dest_sel = 1'b1;
        step();
        bus.npu_sched_sigmoid_input_en = 1'b0;
        checks++;
        if (bus.npu_sfifo_count !== 5'd5) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d, expected 5", bus.npu_sfifo_count);
        end
        rst_n = 1'b0;
        #1;
        test_reset();
        rst_n = 1'b1;
        bus.npu_sigmoid_dout = 16'hDEAD;
        for (int c = 0; c < int'(LAT) + 1; c++) step();
        idle_inputs();
        checks++;
        if (bus.npu_sfifo_empty !== 1'b1 || bus.npu_ofifo_empty !== 1'b1 ||
            bus.npu_sfifo_count !== 5'd0) begin
            errors++;
            $display("FAIL post_reset_write: empty=%b%b count=%0d, expected 11 0",
                     bus.npu_sfifo_empty, bus.npu_ofifo_empty, bus.npu_sfifo_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
        test_single();
        test_back_to_back();
        test_credit();
        test_full_pop_write();
        test_overflow();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/npu_sigmoid_out_buffer.md
# npu_sigmoid_out_buffer

Downstream stage of the NPU sigmoid unit: captures each 16-bit sigmoid result at a fixed latency after the scheduler's `npu_sched_sigmoid_input_en` strobe and routes it to one of two FIFOs. The sigmoid FIFO feeds results back to the PEs as next-layer inputs; the output FIFO holds final-layer results for the host. The block gives the scheduler per-destination credit so it never issues a sigmoid evaluation whose result cannot be stored.

## Interface
Parameters:
- `DATA_W`, 16: result width; must match sigmoid unit output.
- `SIG_LAT`, 2: cycles from `input_en` to a valid `npu_sigmoid_dout`; range ≥ 1.
- `SFIFO_DEPTH`, 16: sigmoid FIFO entries; power of two.
- `OFIFO_DEPTH`, 16: output FIFO entries; power of two.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `npu_rst_n`  in  1  asynchronous, active-low reset.
- `npu_sched_sigmoid_input_en`  in  1  same strobe the sigmoid unit receives.
- `npu_sched_sigmoid_dest_sel`  in  1  0 = sigmoid FIFO, 1 = output FIFO; sampled with `input_en`.
- `npu_sigmoid_dout`  in  DATA_W  sigmoid unit result.
- `npu_sfifo_rd_en`  in  1  PE-side pop.
- `npu_sfifo_dout`  out  DATA_W  head of sigmoid FIFO (first-word fall-through).
- `npu_sfifo_empty`  out  1  sigmoid FIFO empty.
- `npu_sfifo_count`  out  $clog2(SFIFO_DEPTH)+1  sigmoid FIFO occupancy.
- `npu_sfifo_credit`  out  1  scheduler may issue with dest 0.
- `npu_ofifo_rd_en`  in  1  host-side pop.
- `npu_ofifo_dout`  out  DATA_W  head of output FIFO (FWFT).
- `npu_ofifo_empty`  out  1  output FIFO empty.
- `npu_ofifo_credit`  out  1  scheduler may issue with dest 1.
- `npu_overflow_err`  out  1  sticky overflow flag.

## Operation
- Tag pipeline: SIG_LAT registered stages of {valid, dest}. Stage 0 loads {`input_en`, `dest_sel`} every cycle. When the last stage is valid, the current `npu_sigmoid_dout` is written to the FIFO selected by its dest.
- In-flight count per dest is the number of valid pipeline stages carrying that dest.
- Credits are combinational from registered state only:
  - `npu_sfifo_credit` = (sfifo count + in-flight to sfifo) < SFIFO_DEPTH.
  - `npu_ofifo_credit` is defined the same way for the output FIFO.
  - Same-cycle pops are not counted, which makes the credit conservative.
- Write to a full FIFO with no simultaneous pop: the data is dropped, occupancy is unchanged, and `npu_overflow_err` is set. The flag clears only on reset.
- Pop when empty: ignored; pointers and count are unchanged.
- Pop and write on the same FIFO in the same cycle:
  - Both take effect and the count is unchanged.
  - If the FIFO is empty, only the write takes effect and the count increments.
- `*_dout` reads 0 whenever the corresponding FIFO is empty.
- Pointers wrap modulo depth. Full/empty come from the count register, not from pointer comparison.
- Reset (asynchronous, any time): all tag stages are invalidated, in-flight results are discarded, and pointers and counts are cleared. FIFO memory contents are not reset.

## Timing
- `input_en` at cycle t → write at the edge ending cycle t+SIG_LAT → visible at `*_dout` with `*_empty`=0 in cycle t+SIG_LAT+1.
- Back-to-back strobes give one write per cycle (full throughput).
- Pop at cycle t: the next entry (or 0 and empty=1) is presented in cycle t+1.
- Credit deasserts in cycle t+1 after the issuing strobe at t fills the last slot.
- Reset values:
  - `npu_sfifo_empty`=1, `npu_ofifo_empty`=1.
  - `npu_sfifo_count`=0.
  - `npu_sfifo_credit`=1, `npu_ofifo_credit`=1.
  - `npu_sfifo_dout`=0, `npu_ofifo_dout`=0.
  - `npu_overflow_err`=0.

## Structure
- Shared package `npu_pkg`: `NPU_DATA_W` and dest encoding constants `NPU_DEST_SFIFO`=0 and `NPU_DEST_OFIFO`=1.
- Sub-module `npu_fifo` (parameters DATA_W, DEPTH):
  - Count-based FWFT FIFO with zero-when-empty output.
  - Exposes an overflow-drop pulse.
  - Instantiated twice.
- The top level holds the tag pipeline, in-flight counters, credit logic and sticky error.

## Test plan
- Single issue: `input_en` at cycle 10 with dest 0, dout=0x1234 at cycle 12 → sfifo_dout=0x1234, empty=0 and count=1 at cycle 13; ofifo untouched.
- Interleaved burst: 8 strobes on consecutive cycles with dest alternating 0/1 and data 0x0001..0x0008 → sfifo pops 1,3,5,7; ofifo pops 2,4,6,8, in order.
- Credit: 16 strobes to dest 0 with no pops → credit drops the cycle after the 16th strobe; after one pop, credit returns to 1 once the count reaches 15.
- Overflow: force a 17th write while full with no pop → data dropped, count stays 16, err=1 and remains 1 until reset.
- Full with simultaneous pop and write → count stays 16, head advances, err stays 0.
- Reset with 2 results in flight and count=5 → empty=1, count=0, credits=1; no writes occur in the following SIG_LAT cycles.
